// File: rtl/tc08_pkg.sv
// Shared definitions for the TC08 tape read decoder: mark codes, FSM states
// and the default line timeout.
package tc08_pkg;

  localparam int DEFAULT_LINE_TIMEOUT = 8192;

  localparam logic [5:0] MARK_END   = 6'o22;
  localparam logic [5:0] MARK_BLOCK = 6'o26;
  localparam logic [5:0] MARK_GUARD = 6'o32;
  localparam logic [5:0] MARK_LOCK  = 6'o10;
  localparam logic [5:0] MARK_DATA  = 6'o70;
  localparam logic [5:0] MARK_FINAL = 6'o73;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic is_legal(input logic [5:0] code);
    return (code == MARK_END)  || (code == MARK_BLOCK) || (code == MARK_GUARD) ||
           (code == MARK_LOCK) || (code == MARK_DATA)  || (code == MARK_FINAL);
  endfunction

  // Marks after which data lines are assembled into words.
  function automatic logic is_word_mark(input logic [5:0] code);
    return (code == MARK_DATA) || (code == MARK_FINAL);
  endfunction

endpackage

// File: rtl/tc08_diff_rx.sv
// Differential head receiver: synchronizes both halves of a head pair and
// flags the pair active when the synced halves disagree.
module tc08_diff_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pos,
  input  logic neg,
  output logic pos_sync,
  output logic active
);

  logic [SYNC_STAGES-1:0] pos_q;
  logic [SYNC_STAGES-1:0] neg_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= '0;
      neg_q <= '0;
    end else begin
      pos_q <= (pos_q << 1) | SYNC_STAGES'(pos);
      neg_q <= (neg_q << 1) | SYNC_STAGES'(neg);
    end
  end

  assign pos_sync = pos_q[SYNC_STAGES-1];
  assign active   = pos_q[SYNC_STAGES-1] ^ neg_q[SYNC_STAGES-1];

endmodule

// File: rtl/tc08_read_decoder.sv
// TC08 read decoder: recovers tape lines from the timing track, locks onto
// mark-track codes and assembles 12-bit data words from three data tracks.
module tc08_read_decoder
  import tc08_pkg::*;
#(
  parameter int LINE_TIMEOUT = DEFAULT_LINE_TIMEOUT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rev,
  input  logic        t_trk_rd_pos,
  input  logic        t_trk_rd_neg,
  input  logic        rdmk_rd_pos,
  input  logic        rdmk_rd_neg,
  input  logic        rdd_00_rd_pos,
  input  logic        rdd_00_rd_neg,
  input  logic        rdd_01_rd_pos,
  input  logic        rdd_01_rd_neg,
  input  logic        rdd_02_rd_pos,
  input  logic        rdd_02_rd_neg,
  output logic        line_stb,
  output logic        mark_valid,
  output logic [5:0]  mark_code,
  output logic        word_valid,
  output logic [11:0] word,
  output logic        in_sync,
  output logic        tape_moving,
  output logic        mark_err,
  output logic        timing_err
);

  localparam int              GAP_W    = $clog2(LINE_TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(LINE_TIMEOUT - 1);
  localparam logic [5:0]      NO_MARK  = 6'o00;

  // Head index: 0 timing, 1 mark, 2..4 data tracks d00..d02.
  logic [4:0] head_pos, head_neg, pos_s, act;
  assign head_pos = {rdd_02_rd_pos, rdd_01_rd_pos, rdd_00_rd_pos, rdmk_rd_pos, t_trk_rd_pos};
  assign head_neg = {rdd_02_rd_neg, rdd_01_rd_neg, rdd_00_rd_neg, rdmk_rd_neg, t_trk_rd_neg};

  for (genvar i = 0; i < 5; i++) begin : g_rx
    tc08_diff_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
      .clk      (clk),
      .rst      (rst),
      .pos      (head_pos[i]),
      .neg      (head_neg[i]),
      .pos_sync (pos_s[i]),
      .active   (act[i])
    );
  end

  logic unused_act;
  assign unused_act  = ^act[4:1];
  assign tape_moving = act[0];

  logic       t_pos_d, line_rise, stb_q, mbit_q, rev_d;
  logic [2:0] dbits_q;
  assign line_rise = pos_s[0] & ~t_pos_d & tape_moving;
  assign line_stb  = stb_q;

  // Line bits are captured at the edge so the strobe cycle sees a stable set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_pos_d <= 1'b0;
      stb_q   <= 1'b0;
      mbit_q  <= 1'b0;
      dbits_q <= '0;
      rev_d   <= 1'b0;
    end else begin
      t_pos_d <= pos_s[0];
      stb_q   <= line_rise;
      rev_d   <= rev;
      if (line_rise) begin
        mbit_q  <= pos_s[1] ^ rev;
        dbits_q <= {pos_s[2], pos_s[3], pos_s[4]} ^ {3{rev}};
      end
    end
  end

  state_t           state, state_n;
  logic [5:0]       window, window_n, last_mark, last_n, win_shift, mark_code_n;
  logic [2:0]       lphase, lphase_n;
  logic [1:0]       wphase, wphase_n;
  logic [8:0]       wsr, wsr_n;
  logic [GAP_W-1:0] gap_cnt, gap_n;
  logic [11:0]      word_n;
  logic             mark_err_n, timing_err_n, mark_valid_n, word_valid_n, decode;

  assign win_shift = {window[4:0], mbit_q};
  assign in_sync   = (state == LOCKED);

  // NOTE: every signal gets a default at the top of the block, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n      = state;
    window_n     = window;
    lphase_n     = lphase;
    wphase_n     = wphase;
    wsr_n        = wsr;
    gap_n        = gap_cnt;
    last_n       = last_mark;
    mark_err_n   = mark_err;
    timing_err_n = timing_err;
    mark_valid_n = 1'b0;
    mark_code_n  = mark_code;
    word_valid_n = 1'b0;
    word_n       = word;
    decode       = 1'b0;

    if (!tape_moving) begin
      state_n  = IDLE;
      window_n = '0;
      lphase_n = '0;
      gap_n    = '0;
    end else if (rev != rev_d) begin
      state_n  = HUNT;
      window_n = '0;
      lphase_n = '0;
      gap_n    = '0;
    end else begin
      unique case (state)
        IDLE: state_n = HUNT;
        HUNT: begin
          if (stb_q) begin
            window_n = win_shift;
            if (is_legal(win_shift)) begin
              state_n  = LOCKED;
              lphase_n = '0;
              gap_n    = '0;
              decode   = 1'b1;
            end
          end
        end
        LOCKED: begin
          if (stb_q) begin
            window_n = win_shift;
            gap_n    = '0;
            lphase_n = (lphase == 3'd5) ? 3'd0 : lphase + 3'd1;
            if (lphase == 3'd5) begin
              if (is_legal(win_shift)) begin
                decode = 1'b1;
              end else begin
                mark_err_n = 1'b1;
                state_n    = HUNT;
              end
            end
          end else if (gap_cnt == GAP_LAST) begin
            timing_err_n = 1'b1;
            state_n      = HUNT;
            gap_n        = '0;
          end else begin
            gap_n = gap_cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase

      if (decode) begin
        mark_valid_n = 1'b1;
        mark_code_n  = win_shift;
        last_n       = win_shift;
      end

      // A fresh DATA run or any non-word mark discards the partial word.
      if (decode && ((win_shift == MARK_DATA) ? (last_mark != MARK_DATA)
                                              : !is_word_mark(win_shift))) begin
        wphase_n = '0;
        wsr_n    = '0;
      end else if (stb_q && state == LOCKED && is_word_mark(last_mark)) begin
        if (wphase == 2'd3) begin
          word_valid_n = 1'b1;
          word_n       = {wsr, dbits_q};
          wphase_n     = '0;
          wsr_n        = '0;
        end else begin
          wphase_n = wphase + 2'd1;
          wsr_n    = {wsr[5:0], dbits_q};
        end
      end
    end

    if (state_n != LOCKED) begin
      last_n   = NO_MARK;
      wphase_n = '0;
      wsr_n    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      window     <= '0;
      lphase     <= '0;
      wphase     <= '0;
      wsr        <= '0;
      gap_cnt    <= '0;
      last_mark  <= NO_MARK;
      mark_err   <= 1'b0;
      timing_err <= 1'b0;
      mark_valid <= 1'b0;
      mark_code  <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      state      <= state_n;
      window     <= window_n;
      lphase     <= lphase_n;
      wphase     <= wphase_n;
      wsr        <= wsr_n;
      gap_cnt    <= gap_n;
      last_mark  <= last_n;
      mark_err   <= mark_err_n;
      timing_err <= timing_err_n;
      mark_valid <= mark_valid_n;
      mark_code  <= mark_code_n;
      word_valid <= word_valid_n;
      word       <= word_n;
    end
  end

endmodule

// File: tb/tb_tc08_read_decoder.sv
// Scoreboard bench for tc08_read_decoder: a line-level tape model predicts
// marks and words; a negedge monitor compares whatever the decoder emits.
module tb_tc08_read_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rev = 1'b0;
  logic t_trk_rd_pos = 1'b0, t_trk_rd_neg = 1'b0;
  logic rdmk_rd_pos = 1'b0, rdmk_rd_neg = 1'b0;
  logic rdd_00_rd_pos = 1'b0, rdd_00_rd_neg = 1'b0;
  logic rdd_01_rd_pos = 1'b0, rdd_01_rd_neg = 1'b0;
  logic rdd_02_rd_pos = 1'b0, rdd_02_rd_neg = 1'b0;
  logic        line_stb, mark_valid, word_valid, in_sync, tape_moving, mark_err, timing_err;
  logic [5:0]  mark_code;
  logic [11:0] word;

  always #5 clk = ~clk;

  tc08_read_decoder dut (
    .clk(clk), .rst(rst), .rev(rev),
    .t_trk_rd_pos(t_trk_rd_pos), .t_trk_rd_neg(t_trk_rd_neg),
    .rdmk_rd_pos(rdmk_rd_pos), .rdmk_rd_neg(rdmk_rd_neg),
    .rdd_00_rd_pos(rdd_00_rd_pos), .rdd_00_rd_neg(rdd_00_rd_neg),
    .rdd_01_rd_pos(rdd_01_rd_pos), .rdd_01_rd_neg(rdd_01_rd_neg),
    .rdd_02_rd_pos(rdd_02_rd_pos), .rdd_02_rd_neg(rdd_02_rd_neg),
    .line_stb(line_stb), .mark_valid(mark_valid), .mark_code(mark_code),
    .word_valid(word_valid), .word(word), .in_sync(in_sync),
    .tape_moving(tape_moving), .mark_err(mark_err), .timing_err(timing_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0o, expected %0o (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues and counters.
  logic [5:0]  exp_marks[$];
  logic [11:0] exp_words[$];
  int          lines_sent, stb_seen, words_seen;
  logic [11:0] first_word;

  // Tape model state: last six mark bits, lock flag, lines since lock, last mark.
  int m_hist, m_cnt, m_last;
  bit m_locked, m_err;
  int m_digits[$];
  int dig_q[$];
  int legal_codes[6] = '{'o22, 'o26, 'o32, 'o10, 'o70, 'o73};

  function automatic bit legal(input int code);
    foreach (legal_codes[i]) if (legal_codes[i] == code) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit word_mark(input int code);
    return (code == 'o70) || (code == 'o73);
  endfunction

  task automatic model_idle();
    m_hist = 0; m_cnt = 0; m_last = 0; m_locked = 0;
    m_digits.delete();
  endtask

  task automatic add_digit(input int d);
    m_digits.push_back(d);
    if (m_digits.size() == 4) begin
      exp_words.push_back(12'((m_digits[0] << 9) | (m_digits[1] << 6) | (m_digits[2] << 3) | m_digits[3]));
      m_digits.delete();
    end
  endtask

  task automatic model_line(input bit mb, input int digit);
    int decoded = -1;
    int prev = m_last;
    lines_sent++;
    m_hist = ((m_hist << 1) | int'(mb)) & 63;
    if (!m_locked) begin
      if (legal(m_hist)) begin
        m_locked = 1; m_cnt = 0; decoded = m_hist;
      end
    end else begin
      m_cnt = (m_cnt + 1) % 6;
      if (m_cnt == 0) begin
        if (legal(m_hist)) decoded = m_hist;
        else begin m_err = 1; m_locked = 0; end
      end
    end
    if (!m_locked) begin
      m_last = 0;
      m_digits.delete();
    end else if (decoded >= 0) begin
      exp_marks.push_back(6'(decoded));
      if ((decoded == 'o70 && prev != 'o70) || !word_mark(decoded)) m_digits.delete();
      else if (word_mark(prev)) add_digit(digit);
      m_last = decoded;
    end else if (word_mark(prev)) begin
      add_digit(digit);
    end
  endtask

  // Monitor: pops expectations whenever the decoder presents a result.
  always @(negedge clk) begin
    if (!rst) begin
      if (line_stb) stb_seen++;
      if (mark_valid) begin
        if (exp_marks.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_mark: got %0o, expected none", mark_code);
        end else check("mark_code", 32'(mark_code), 32'(exp_marks.pop_front()));
      end
      if (word_valid) begin
        if (words_seen == 0) first_word = word;
        words_seen++;
        if (exp_words.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got %0o, expected none", word);
        end else check("word", 32'(word), 32'(exp_words.pop_front()));
      end
    end
  end

  task automatic next_digit(output int d);
    if (dig_q.size() != 0) d = dig_q.pop_front();
    else d = int'($urandom_range(0, 7));
  endtask

  task automatic send_line(input bit mb, input int digit);
    logic [2:0] d3;
    d3 = 3'(digit);
    model_line(mb, digit);
    rdmk_rd_pos   = mb ^ rev;    rdmk_rd_neg   = ~(mb ^ rev);
    rdd_00_rd_pos = d3[2] ^ rev; rdd_00_rd_neg = ~(d3[2] ^ rev);
    rdd_01_rd_pos = d3[1] ^ rev; rdd_01_rd_neg = ~(d3[1] ^ rev);
    rdd_02_rd_pos = d3[0] ^ rev; rdd_02_rd_neg = ~(d3[0] ^ rev);
    repeat (2) @(posedge clk); #1;
    t_trk_rd_pos = 1'b1; t_trk_rd_neg = 1'b0;
    repeat (4) @(posedge clk); #1;
    t_trk_rd_pos = 1'b0; t_trk_rd_neg = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("in_sync", 32'(in_sync), 32'(m_locked));
  endtask

  task automatic send_mark(input logic [5:0] code);
    for (int i = 5; i >= 0; i--) begin
      int d;
      next_digit(d);
      send_line(code[i], d);
    end
  endtask

  task automatic start_tape();
    t_trk_rd_pos = 1'b0; t_trk_rd_neg = 1'b1;
    repeat (5) @(posedge clk); #1;
  endtask

  task automatic stop_tape();
    t_trk_rd_pos = 1'b0; t_trk_rd_neg = 1'b0;
    repeat (5) @(posedge clk); #1;
    model_idle();
    check("stopped_tape_moving", 32'(tape_moving), 0);
    check("stopped_in_sync", 32'(in_sync), 0);
  endtask

  task automatic all_pins_low();
    t_trk_rd_pos = 0; t_trk_rd_neg = 0; rdmk_rd_pos = 0; rdmk_rd_neg = 0;
    rdd_00_rd_pos = 0; rdd_00_rd_neg = 0; rdd_01_rd_pos = 0; rdd_01_rd_neg = 0;
    rdd_02_rd_pos = 0; rdd_02_rd_neg = 0;
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1;
    all_pins_low();
    repeat (3) @(posedge clk); #1;
    check("outputs_in_reset", 32'({line_stb, mark_valid, mark_code, word_valid, word,
                                   in_sync, tape_moving, mark_err, timing_err}), 0);
    rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("outputs_after_reset", 32'({line_stb, mark_valid, mark_code, word_valid, word,
                                      in_sync, tape_moving, mark_err, timing_err}), 0);
  endtask

  task automatic begin_test();
    do_reset();
    model_idle();
    m_err = 0;
    exp_marks.delete(); exp_words.delete(); dig_q.delete();
    lines_sent = 0; stb_seen = 0; words_seen = 0;
  endtask

  task automatic end_test();
    stop_tape();
    check("marks_left", 32'(exp_marks.size()), 0);
    check("words_left", 32'(exp_words.size()), 0);
    check("line_count", 32'(stb_seen), 32'(lines_sent));
  endtask

  task automatic forward_stream(input string tag);
    int n_words;
    start_tape();
    send_mark(6'o22); send_mark(6'o26); send_mark(6'o70);
    dig_q = '{7, 0, 5, 2};
    send_mark(6'o70); send_mark(6'o70); send_mark(6'o70);
    send_mark(6'o73); send_mark(6'o22);
    n_words = words_seen + exp_words.size();
    end_test();
    check({tag, "_first_word"}, 32'(first_word), 'o7052);
    check({tag, "_word_count"}, 32'(words_seen), 32'(n_words));
    check({tag, "_errors"}, 32'({mark_err, timing_err}), 0);
  endtask

  initial begin
    // Forward stream: END, BLOCK, DATA, then words starting 7052.
    begin_test();
    forward_stream("fwd");

    // Reverse direction with complemented heads decodes the same words.
    rev = 1'b1;
    begin_test();
    forward_stream("rev");
    rev = 1'b0;

    // Corrupted mark after lock, then relock on the next legal code.
    begin_test();
    start_tape();
    send_mark(6'o22); send_mark(6'o26);
    send_mark(6'o70 ^ 6'o01);
    check("mark_err_set", 32'(mark_err), 32'(m_err));
    check("unlocked_after_bad_mark", 32'(in_sync), 0);
    send_mark(6'o26); send_mark(6'o70); send_mark(6'o70); send_mark(6'o70);
    check("relocked", 32'(in_sync), 1);
    check("mark_err_sticky", 32'(mark_err), 1);
    end_test();

    // Timing track stalls with the pair still active.
    begin_test();
    start_tape();
    send_mark(6'o22); send_mark(6'o26); send_mark(6'o70);
    repeat (9000) @(posedge clk); #1;
    model_idle();
    check("timing_err_set", 32'(timing_err), 1);
    check("hunt_after_timeout", 32'({in_sync, tape_moving}), 32'b01);
    end_test();
    check("timing_err_sticky", 32'(timing_err), 1);

    // Reset asserted two lines into a word drops it.
    begin_test();
    start_tape();
    send_mark(6'o22); send_mark(6'o26); send_mark(6'o70);
    send_line(1'b1, 3); send_line(1'b1, 4);
    exp_words.delete();
    do_reset();
    repeat (20) @(posedge clk); #1;
    check("no_word_after_rst", 32'(words_seen), 0);
    check("idle_after_rst", 32'({in_sync, tape_moving}), 0);

    // Timing pair inactive (both pins equal): no motion, no strobes.
    begin_test();
    for (int i = 0; i < 4; i++) begin
      t_trk_rd_pos = 1'b1; t_trk_rd_neg = 1'b1;
      repeat (6) @(posedge clk); #1;
      check("inactive_tape_moving", 32'(tape_moving), 0);
      t_trk_rd_pos = 1'b0; t_trk_rd_neg = 1'b0;
      repeat (6) @(posedge clk); #1;
    end
    check("inactive_no_strobe", 32'(stb_seen), 0);
    check("inactive_in_sync", 32'(in_sync), 0);

    // Random legal mark stream with random data.
    begin_test();
    start_tape();
    for (int i = 0; i < 24; i++) begin
      if (i < 2) send_mark(6'o26);
      else send_mark(6'(legal_codes[$urandom_range(0, 5)]));
    end
    end_test();
    check("random_errors", 32'({mark_err, timing_err}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
